cont_seq_ctrl: RTL and testbench

Sequencing controller for the 4-bit counter datapath. It starts, pauses, resumes, loads and bounds the count.
- Programmable prescaled rate, direction, terminal limit, and continuous (wrap) or one-shot mode.
- Sits between the system control/stimulus and the counter output consumed downstream.
- Reports Busy, a one-shot Done pulse and a Wrap pulse.

---
 rtl/cont_pkg.sv | 13 +
 rtl/cont_prescaler.sv | 26 ++
 rtl/cont_seq_ctrl.sv | 83 ++++++++
 tb/tb_cont_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cont_pkg.sv
// cont_pkg: shared state encoding, direction/mode codes and default widths
// for the counter sequencing controller.
package cont_pkg;
    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_PRESCALE_W = 4;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
endpackage

// File: rtl/cont_prescaler.sv
// cont_prescaler: rate divider that emits one tick every div+1 enabled cycles;
// holds its count while disabled so a paused run resumes mid-period.
module cont_prescaler #(
    parameter int PRESCALE_W = cont_pkg::DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt;

    // >= keeps the period bounded if div is lowered below the current count
    assign tick = en && (cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/cont_seq_ctrl.sv
// cont_seq_ctrl: start/stop/load sequencer for a bounded up/down counter with
// prescaled rate, continuous-wrap or one-shot completion, and status pulses.
module cont_seq_ctrl #(
    parameter int WIDTH      = cont_pkg::DEFAULT_WIDTH,
    parameter int PRESCALE_W = cont_pkg::DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  dir,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] div,
    output logic [WIDTH-1:0]      out,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);
    import cont_pkg::*;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  out_nxt;
    logic              done_nxt, wrap_nxt, en, clr, tick, at_end;

    // Load outranks everything; a fresh start (not a resume) restarts the period
    assign en     = (state == RUN) && !load && !stop;
    assign clr    = load || (start && !stop && (state == IDLE || state == DONE));
    assign at_end = (dir == DIR_DOWN) ? (out == '0) : (out == limit);

    cont_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        done_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (load) begin
            out_nxt = load_val;
            if (state == DONE) state_nxt = IDLE;
        end else if (stop) begin
            if (state == RUN) state_nxt = HOLD;
        end else if (start && state != RUN) begin
            state_nxt = RUN;
            if (state == DONE) out_nxt = (dir == DIR_DOWN) ? limit : '0;
        end else if (tick) begin
            if (!at_end)
                out_nxt = (dir == DIR_DOWN) ? out - 1'b1 : out + 1'b1;
            else if (mode == MODE_ONESHOT) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end else begin
                out_nxt  = (dir == DIR_DOWN) ? limit : '0;
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            busy  <= (state_nxt == RUN);
            done  <= done_nxt;
            wrap  <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_cont_seq_ctrl.sv
// tb_cont_seq_ctrl: directed scenario tasks for cont_seq_ctrl with
// hand-computed expected counts and status flags.
module tb_cont_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0, limit = '0;
    logic       dir = 1'b0, mode = 1'b0;
    logic [3:0] div = '0;
    logic [3:0] out;
    logic       busy, done, wrap;
    int         checks = 0, passed = 0;

    cont_seq_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .limit(limit), .dir(dir), .mode(mode), .div(div),
        .out(out), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {start, stop, load, dir, mode} = '0;
        load_val = '0; limit = '0; div = '0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, busy, done, wrap} !== 7'b0) $display("FAIL reset_state got=%b exp=%b", {out, busy, done, wrap}, 7'b0);
        else passed++;
        #3 rst_n = 1'b1;
        limit = 4'd15;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        checks++;
        if ({out, busy} !== {4'd7, 1'b1}) $display("FAIL pre_reset_run got=%0d/%b exp=7/1", out, busy);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out, busy} !== 5'b0) $display("FAIL async_reset got=%0d/%b exp=0/0", out, busy);
        else passed++;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy} !== {4'd0, 1'b1}) $display("FAIL restart_enter got=%0d/%b exp=0/1", out, busy);
        else passed++;
        step();
        checks++;
        if (out !== 4'd1) $display("FAIL restart_count got=%0d exp=1", out);
        else passed++;
    endtask

    task automatic test_up_wrap();
        do_reset();
        limit = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy} !== {4'd0, 1'b1}) $display("FAIL upwrap_enter got=%0d/%b exp=0/1", out, busy);
        else passed++;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if ({out, busy, wrap} !== {4'(i), 2'b10}) $display("FAIL upwrap_count got=%0d/%b/%b exp=%0d/1/0", out, busy, wrap, i);
            else passed++;
        end
        step();
        checks++;
        if ({out, busy, done, wrap} !== {4'd0, 3'b101}) $display("FAIL upwrap_wrap got=%0d/%b/%b/%b exp=0/1/0/1", out, busy, done, wrap);
        else passed++;
        step();
        checks++;
        if ({out, wrap} !== {4'd1, 1'b0}) $display("FAIL upwrap_after got=%0d/%b exp=1/0", out, wrap);
        else passed++;
    endtask

    task automatic test_down_oneshot();
        do_reset();
        dir = 1'b1; mode = 1'b1; div = 4'd2; limit = 4'd9;
        load = 1'b1; load_val = 4'd5;
        step();
        load = 1'b0;
        checks++;
        if ({out, busy} !== {4'd5, 1'b0}) $display("FAIL oneshot_load got=%0d/%b exp=5/0", out, busy);
        else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int v = 4; v >= 0; v--) begin
            step(); step();
            checks++;
            if (out !== 4'(v + 1)) $display("FAIL oneshot_hold_rate got=%0d exp=%0d", out, v + 1);
            else passed++;
            step();
            checks++;
            if ({out, busy, done} !== {4'(v), 2'b10}) $display("FAIL oneshot_tick got=%0d/%b/%b exp=%0d/1/0", out, busy, done, v);
            else passed++;
        end
        step(); step();
        checks++;
        if ({out, busy, done} !== {4'd0, 2'b10}) $display("FAIL oneshot_predone got=%0d/%b/%b exp=0/1/0", out, busy, done);
        else passed++;
        step();
        checks++;
        if ({out, busy, done, wrap} !== {4'd0, 3'b010}) $display("FAIL oneshot_done got=%0d/%b/%b/%b exp=0/0/1/0", out, busy, done, wrap);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({out, busy, done} !== 6'b0) $display("FAIL oneshot_stay got=%0d/%b/%b exp=0/0/0", out, busy, done);
            else passed++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy} !== {4'd9, 1'b1}) $display("FAIL done_restart got=%0d/%b exp=9/1", out, busy);
        else passed++;
    endtask

    task automatic test_pause_resume();
        do_reset();
        limit = 4'd15;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        checks++;
        if (out !== 4'd4) $display("FAIL pause_prep got=%0d exp=4", out);
        else passed++;
        stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({out, busy} !== {4'd4, 1'b0}) $display("FAIL pause_hold got=%0d/%b exp=4/0", out, busy);
            else passed++;
        end
        stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy} !== {4'd4, 1'b1}) $display("FAIL resume_enter got=%0d/%b exp=4/1", out, busy);
        else passed++;
        step();
        checks++;
        if (out !== 4'd5) $display("FAIL resume_tick got=%0d exp=5", out);
        else passed++;
    endtask

    task automatic test_priority();
        logic [3:0] exp_seq [8] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        do_reset();
        start = 1'b1; stop = 1'b1;
        step(); step();
        checks++;
        if ({out, busy} !== 5'b0) $display("FAIL start_stop_idle got=%0d/%b exp=0/0", out, busy);
        else passed++;
        stop = 1'b0;
        load = 1'b1; load_val = 4'd12;
        step();
        load = 1'b0;
        checks++;
        if ({out, busy} !== {4'd12, 1'b0}) $display("FAIL load_start got=%0d/%b exp=12/0", out, busy);
        else passed++;
        limit = 4'd3;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy} !== {4'd12, 1'b1}) $display("FAIL load_run_enter got=%0d/%b exp=12/1", out, busy);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({out, wrap} !== {exp_seq[i], (i == 7)}) $display("FAIL above_limit_seq%0d got=%0d/%b exp=%0d/%b", i, out, wrap, exp_seq[i], i == 7);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        limit = 4'd15; dir = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({out, wrap} !== {4'd15, 1'b1}) $display("FAIL down_reload got=%0d/%b exp=15/1", out, wrap);
        else passed++;
        step();
        checks++;
        if ({out, wrap} !== {4'd14, 1'b0}) $display("FAIL down_next got=%0d/%b exp=14/0", out, wrap);
        else passed++;
        dir = 1'b0;
        step();
        checks++;
        if ({out, wrap} !== {4'd15, 1'b0}) $display("FAIL dir_switch got=%0d/%b exp=15/0", out, wrap);
        else passed++;
        step();
        checks++;
        if ({out, wrap, done} !== {4'd0, 2'b10}) $display("FAIL up_wrap_after_switch got=%0d/%b/%b exp=0/1/0", out, wrap, done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_oneshot();
        test_pause_resume();
        test_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
